serial_subtractor: RTL and testbench

Bit-serial full subtractor built from a single full-subtractor cell and a borrow flip-flop; it is the inverse-arithmetic counterpart of the lab's combinational NAND-gate adder cell. It accepts two WIDTH-bit operands on a start strobe and processes one bit per clock, LSB first. It reports the difference, the final borrow and signed overflow with a one-cycle done pulse. It sits between the lab's operand registers and the result display/checker logic.

---
 rtl/serial_subtractor.sv | 130 +++++++++++++
 tb/tb_serial_subtractor.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell plus a borrow flip-flop, LSB first.
// Result, final borrow and signed overflow are registered and announced by a one-cycle done pulse.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic fs_diff(input logic x, input logic y, input logic bi);
        return x ^ y ^ bi;
    endfunction

    function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
        return (~x & y) | (~(x ^ y) & bi);
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] diff_sh_r;
    logic             br_r;
    logic [CW-1:0]    cnt_r;
    logic             a_msb_r;
    logic             b_msb_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_r;
    logic             ovf_r;

    logic             d_s;
    logic             bo_s;
    logic [WIDTH-1:0] diff_next_s;

    // Full-subtractor cell on the current LSBs and the stored borrow
    always_comb begin
        d_s         = fs_diff(a_sh_r[0], b_sh_r[0], br_r);
        bo_s        = fs_borrow(a_sh_r[0], b_sh_r[0], br_r);
        diff_next_s = {d_s, diff_sh_r[WIDTH-1:1]};
    end

    // Control FSM, datapath shift registers and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            a_sh_r    <= '0;
            b_sh_r    <= '0;
            diff_sh_r <= '0;
            br_r      <= 1'b0;
            cnt_r     <= '0;
            a_msb_r   <= 1'b0;
            b_msb_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            diff_r    <= '0;
            borrow_r  <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b;
                        br_r    <= bin;
                        cnt_r   <= '0;
                        a_msb_r <= a[WIDTH-1];
                        b_msb_r <= b[WIDTH-1];
                        busy_r  <= 1'b1;
                        state_r <= SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                SHIFT: begin
                    diff_sh_r <= diff_next_s;
                    a_sh_r    <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r    <= {1'b0, b_sh_r[WIDTH-1:1]};
                    br_r      <= bo_s;
                    if (cnt_r == LAST_CNT) begin
                        // Last bit: publish the result on the same edge that enters DONE
                        state_r  <= DONE;
                        done_r   <= 1'b1;
                        diff_r   <= diff_next_s;
                        borrow_r <= bo_s;
                        ovf_r    <= (a_msb_r != b_msb_r) && (diff_next_s[WIDTH-1] != a_msb_r);
                    end else begin
                        cnt_r    <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign diff   = diff_r;
    assign borrow = borrow_r;
    assign ovf    = ovf_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor (WIDTH = 8): result values,
// done timing, ignored starts, back-to-back operation and asynchronous reset.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .bin    (bin),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {ovf, borrow, diff} of a - b - bin
    function automatic logic [9:0] ref_sub(input logic [7:0] x, input logic [7:0] y, input logic bi);
        logic [8:0] r;
        logic       o;
        r = {1'b0, x} - {1'b0, y} - {8'd0, bi};
        o = (x[7] != y[7]) && (r[7] != x[7]);
        return {o, r};
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (busy) check_eq("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                          input logic tbin, input logic [7:0] ed, input logic eb, input logic eo);
        int n;
        wait_idle();
        a = ta; b = tb; bin = tbin; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~ta; b = ~tb; bin = ~tbin;
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(n);
        check_eq({tag, "_lat"}, 32'(n), 32'd8);
        check_eq({tag, "_diff"}, 32'(diff), 32'(ed));
        check_eq({tag, "_borrow"}, 32'(borrow), 32'(eb));
        check_eq({tag, "_ovf"}, 32'(ovf), 32'(eo));
        @(posedge clk);
        #1;
        check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
        check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int          k;
        int          pulses;
        logic [7:0]  ra, rb;
        logic        rbin;
        logic [9:0]  ex;

        rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_diff", 32'(diff), 32'd0);
        check_eq("rst_bo", 32'(borrow), 32'd0);
        check_eq("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("v05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        run_op("v03_05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
        run_op("v80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op("v7F_FF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        run_op("v00_00_b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op("vFF_FF", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);

        // Start while busy is ignored and operand changes after capture are harmless
        wait_idle();
        a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a = 8'h00; b = 8'h01; bin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = 8'hAA; b = 8'h55;
        wait_done(k);
        check_eq("ign_lat", 32'(k), 32'd5);
        check_eq("ign_diff", 32'(diff), 32'h0F);
        check_eq("ign_bo", 32'(borrow), 32'd0);
        run_op("after_ign", 8'h20, 8'h30, 1'b1, 8'hEF, 1'b1, 1'b0);

        // Start held high: ignored in DONE, re-accepted on the first IDLE cycle
        wait_idle();
        a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(k);
        check_eq("b2b_lat1", 32'(k), 32'd8);
        check_eq("b2b_diff1", 32'(diff), 32'h02);
        a = 8'h03; b = 8'h05;
        @(posedge clk);
        #1;
        check_eq("b2b_gap_busy", 32'(busy), 32'd0);
        k = 1;
        while (!done && k < 30) begin
            @(posedge clk);
            #1;
            k++;
        end
        start = 1'b0;
        check_eq("b2b_lat2", 32'(k), 32'd10);
        check_eq("b2b_diff2", 32'(diff), 32'hFE);
        check_eq("b2b_bo2", 32'(borrow), 32'd1);

        // Asynchronous reset in the middle of a shift
        wait_idle();
        a = 8'h40; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_done", 32'(done), 32'd0);
        check_eq("arst_diff", 32'(diff), 32'd0);
        check_eq("arst_bo", 32'(borrow), 32'd0);
        check_eq("arst_ovf", 32'(ovf), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check_eq("arst_no_done", 32'(pulses), 32'd0);
        run_op("post_rst", 8'h40, 8'h01, 1'b0, 8'h3F, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rbin = 1'($urandom_range(0, 1));
            ex   = ref_sub(ra, rb, rbin);
            run_op("rand", ra, rb, rbin, ex[7:0], ex[8], ex[9]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
